// File: rtl/mult_share_pkg.sv
// Shared constants and helpers for the time-shared multiplier scheduler.
package mult_share_pkg;

    localparam int MS_WIDTH = 16;
    localparam int MS_NREQ  = 4;
    localparam int MS_LAT   = 2;

    // Index width; never zero so a single-requester build still has a 1-bit id.
    function automatic int ms_id_w(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

endpackage

// File: rtl/mult_share_rr_arb.sv
// Round-robin arbiter: scans from the pointer upward with wrap and grants the
// first valid requester; the pointer moves past the winner on each grant.
module mult_share_rr_arb
    import mult_share_pkg::*;
#(
    parameter  int NREQ = MS_NREQ,
    localparam int ID_W = ms_id_w(NREQ)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] valid,
    input  logic            en,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_idx
);

    logic [ID_W-1:0] ptr;
    logic [ID_W-1:0] ptr_nxt;
    logic [ID_W:0]   cand;
    logic [ID_W:0]   idx_inc;
    logic            found;

    // NOTE: always_comb uses blocking assignments; every variable it writes is
    // given a default first so no latch is inferred on the no-grant path.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (en && !found && valid[cand[ID_W-1:0]]) begin
                found                    = 1'b1;
                grant[cand[ID_W-1:0]]    = 1'b1;
                grant_idx                = cand[ID_W-1:0];
            end
        end
    end

    always_comb begin
        idx_inc = {1'b0, grant_idx} + (ID_W+1)'(1);
        ptr_nxt = (idx_inc >= (ID_W+1)'(NREQ)) ? '0 : idx_inc[ID_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (found) begin
            ptr <= ptr_nxt;
        end
    end

endmodule

// File: rtl/mult_share_sched.sv
// Time-shares one truncated WIDTH x WIDTH multiplier among NREQ requesters.
// Define MULT_SHARE_SCHED_OVF_EN to add the rsp_ovf upper-half-nonzero flag.
module mult_share_sched
    import mult_share_pkg::*;
#(
    parameter  int WIDTH = MS_WIDTH,
    parameter  int NREQ  = MS_NREQ,
    parameter  int LAT   = MS_LAT,
    localparam int ID_W  = ms_id_w(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [WIDTH-1:0]      rsp_data
`ifdef MULT_SHARE_SCHED_OVF_EN
    ,
    output logic                  rsp_ovf
`endif
);

    logic             stall;
    logic             xfer;
    logic [ID_W-1:0]  sel_idx;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] prod;

    logic             s_valid [LAT];
    logic [ID_W-1:0]  s_id    [LAT];
    logic [WIDTH-1:0] s_data  [LAT];

    // The whole pipeline freezes on backpressure; no bubble collapsing.
    assign stall = rsp_valid && !rsp_ready;

    mult_share_rr_arb #(
        .NREQ (NREQ)
    ) u_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (req_valid),
        .en        (!stall),
        .grant     (req_ready),
        .grant_idx (sel_idx)
    );

    assign xfer  = |req_ready;
    assign a_sel = req_a[sel_idx*WIDTH +: WIDTH];
    assign b_sel = req_b[sel_idx*WIDTH +: WIDTH];

`ifdef MULT_SHARE_SCHED_OVF_EN
    logic [2*WIDTH-1:0] full;
    logic               hi_nz;
    logic               s_ovf [LAT];

    assign full  = (2*WIDTH)'(a_sel) * (2*WIDTH)'(b_sel);
    assign prod  = full[WIDTH-1:0];
    assign hi_nz = |full[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                s_ovf[i] <= 1'b0;
            end
        end else if (!stall) begin
            s_ovf[0] <= hi_nz;
            for (int i = 1; i < LAT; i++) begin
                s_ovf[i] <= s_ovf[i-1];
            end
        end
    end

    assign rsp_ovf = s_ovf[LAT-1];
`else
    assign prod = a_sel * b_sel;
`endif

    // NOTE: id/data stages are reset along with the valids so an empty stage
    // never presents X on the response bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                s_valid[i] <= 1'b0;
                s_id[i]    <= '0;
                s_data[i]  <= '0;
            end
        end else if (!stall) begin
            s_valid[0] <= xfer;
            s_id[0]    <= sel_idx;
            s_data[0]  <= prod;
            for (int i = 1; i < LAT; i++) begin
                s_valid[i] <= s_valid[i-1];
                s_id[i]    <= s_id[i-1];
                s_data[i]  <= s_data[i-1];
            end
        end
    end

    assign rsp_valid = s_valid[LAT-1];
    assign rsp_id    = s_id[LAT-1];
    assign rsp_data  = s_data[LAT-1];

endmodule

// File: tb/tb_mult_share_sched.sv
// Randomised and directed bench for mult_share_sched against a queue-based
// model of round-robin grants and in-order truncated products.
module tb_mult_share_sched;
    import mult_share_pkg::*;

    localparam int W  = MS_WIDTH;
    localparam int N  = MS_NREQ;
    localparam int L  = MS_LAT;
    localparam int IW = ms_id_w(N);

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_ready;
    logic [N*W-1:0] req_a = '0;
    logic [N*W-1:0] req_b = '0;
    logic           rsp_valid;
    logic           rsp_ready = 1'b1;
    logic [IW-1:0]  rsp_id;
    logic [W-1:0]   rsp_data;
`ifdef MULT_SHARE_SCHED_OVF_EN
    logic           rsp_ovf;
`endif

    typedef struct {
        int         id;
        logic [W-1:0] data;
        logic       ovf;
    } exp_t;

    exp_t         q[$];
    int           mptr;
    int           errors = 0;
    int           checks = 0;
    logic [N-1:0] obs_ready;
    int           ready_hi[N];

    mult_share_sched #(
        .WIDTH (W),
        .NREQ  (N),
        .LAT   (L)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
`ifdef MULT_SHARE_SCHED_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic exp_t model(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t            e;
        longint unsigned fa;
        longint unsigned fb;
        longint unsigned full;
        fa     = a;
        fb     = b;
        full   = fa * fb;
        e.id   = id;
        e.data = W'(full % (64'd1 << W));
        e.ovf  = (full >> W) != 0;
        return e;
    endfunction

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            set_ops(i, W'($urandom), W'($urandom));
        end
    endtask

    // One clock: called at a falling edge with inputs already driven.
    task automatic cycle();
        int           g;
        logic [N-1:0] exp_ready;
        exp_t         e;
        #1;
        g = -1;
        if (!(rsp_valid === 1'b1 && rsp_ready === 1'b0)) begin
            for (int k = 0; k < N; k++) begin
                if (g < 0 && req_valid[(mptr + k) % N]) g = (mptr + k) % N;
            end
        end
        exp_ready = '0;
        if (g >= 0) exp_ready[g] = 1'b1;
        obs_ready = req_ready;
        for (int i = 0; i < N; i++) if (req_ready[i] === 1'b1) ready_hi[i]++;
        checks++;
        if (req_ready !== exp_ready) begin
            errors++;
            $display("FAIL req_ready: got %b expected %b", req_ready, exp_ready);
        end
        if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL rsp_unexpected: got id=%0d data=%h expected no response", rsp_id, rsp_data);
            end else begin
                e = q.pop_front();
                if (rsp_id !== IW'(e.id) || rsp_data !== e.data) begin
                    errors++;
                    $display("FAIL rsp_order: got id=%0d data=%h expected id=%0d data=%h",
                             rsp_id, rsp_data, e.id, e.data);
                end
`ifdef MULT_SHARE_SCHED_OVF_EN
                checks++;
                if (rsp_ovf !== e.ovf) begin
                    errors++;
                    $display("FAIL rsp_ovf: got %b expected %b", rsp_ovf, e.ovf);
                end
`endif
            end
        end
        if (g >= 0) begin
            q.push_back(model(g, req_a[g*W +: W], req_b[g*W +: W]));
            mptr = (g + 1) % N;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        rsp_ready = 1'b1;
        q.delete();
        mptr = 0;
        for (int i = 0; i < N; i++) ready_hi[i] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 20) begin
            cycle();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_timeout: got rsp_valid=%b expected 1 within 20 cycles", rsp_valid);
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0;
        rsp_ready = 1'b1;
        while (q.size() != 0 && n < 40) begin
            cycle();
            n++;
        end
        checks++;
        if (q.size() != 0 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL drain: got pending=%0d rsp_valid=%b expected 0 and 0", q.size(), rsp_valid);
        end
    endtask

    task automatic test_reset();
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b id=%0d data=%h expected 0/0/0", rsp_valid, rsp_id, rsp_data);
        end
        @(negedge clk);
        do_reset();
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0) begin
            errors++;
            $display("FAIL reset_release: got v=%b id=%0d data=%h expected 0/0/0", rsp_valid, rsp_id, rsp_data);
        end
        rand_ops();
        req_valid = '1;
        cycle();
        checks++;
        if (obs_ready !== N'(1)) begin
            errors++;
            $display("FAIL reset_pointer: got req_ready=%b expected %b", obs_ready, N'(1));
        end
        drain();
    endtask

    task automatic test_single();
        int n;
        do_reset();
        set_ops(2, W'(3), W'(5));
        req_valid = N'(1) << 2;
        cycle();
        req_valid = '0;
        wait_rsp(n);
        checks++;
        if (n != L - 1) begin
            errors++;
            $display("FAIL single_latency: got %0d extra cycles expected %0d", n, L - 1);
        end
        checks++;
        if (rsp_id !== IW'(2) || rsp_data !== W'(15)) begin
            errors++;
            $display("FAIL single_result: got id=%0d data=%0d expected id=2 data=15", rsp_id, rsp_data);
        end
        drain();
        checks++;
        if (ready_hi[2] != 1) begin
            errors++;
            $display("FAIL single_ready_pulse: got %0d cycles expected 1", ready_hi[2]);
        end
    endtask

    task automatic test_round_robin();
        logic [N-1:0] exp;
        do_reset();
        req_valid = '1;
        for (int k = 0; k < 3 * N; k++) begin
            rand_ops();
            cycle();
            exp = N'(1) << (k % N);
            checks++;
            if (obs_ready !== exp) begin
                errors++;
                $display("FAIL rr_grant: cycle %0d got %b expected %b", k, obs_ready, exp);
            end
            if (k >= L - 1) begin
                checks++;
                if (rsp_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL rr_back_to_back: cycle %0d got rsp_valid=%b expected 1", k, rsp_valid);
                end
            end
        end
        drain();
    endtask

    task automatic test_truncation();
        int n;
        do_reset();
        set_ops(0, 16'hFFFF, 16'h0002);
        req_valid = N'(1);
        cycle();
        set_ops(0, 16'h00FF, 16'h00FF);
        cycle();
        req_valid = '0;
        wait_rsp(n);
        checks++;
        if (rsp_data !== W'(16'hFFFE)) begin
            errors++;
            $display("FAIL trunc_ffff: got %h expected fffe", rsp_data);
        end
`ifdef MULT_SHARE_SCHED_OVF_EN
        checks++;
        if (rsp_ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_set: got %b expected 1", rsp_ovf);
        end
`endif
        cycle();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_data !== W'(16'hFE01)) begin
            errors++;
            $display("FAIL trunc_00ff: got v=%b data=%h expected v=1 data=fe01", rsp_valid, rsp_data);
        end
`ifdef MULT_SHARE_SCHED_OVF_EN
        checks++;
        if (rsp_ovf !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clear: got %b expected 0", rsp_ovf);
        end
`endif
        drain();
    endtask

    task automatic test_backpressure();
        do_reset();
        req_valid = '1;
        for (int k = 0; k < L; k++) begin
            rand_ops();
            cycle();
        end
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            rand_ops();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== IW'(q[0].id) || rsp_data !== q[0].data) begin
                errors++;
                $display("FAIL stall_hold: cycle %0d got v=%b id=%0d data=%h expected v=1 id=%0d data=%h",
                         k, rsp_valid, rsp_id, rsp_data, q[0].id, q[0].data);
            end
            cycle();
            checks++;
            if (obs_ready !== '0) begin
                errors++;
                $display("FAIL stall_ready: cycle %0d got %b expected 0", k, obs_ready);
            end
        end
        rsp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_ops();
            cycle();
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        do_reset();
        rand_ops();
        req_valid = N'(1);
        cycle();
        req_valid = N'(2);
        cycle();
        req_valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got rsp_valid=%b expected 0", rsp_valid);
        end
        q.delete();
        mptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < L + 2; k++) begin
            cycle();
            checks++;
            if (rsp_valid !== 1'b0) begin
                errors++;
                $display("FAIL stale_response: cycle %0d got rsp_valid=%b expected 0", k, rsp_valid);
            end
        end
        req_valid = N'(1) | (N'(1) << (N - 1));
        cycle();
        checks++;
        if (obs_ready !== N'(1)) begin
            errors++;
            $display("FAIL reset_contention: got %b expected %b", obs_ready, N'(1));
        end
        drain();
    endtask

    task automatic test_sparse();
        do_reset();
        rand_ops();
        req_valid = N'(2);
        cycle();
        req_valid = N'(2) | N'(8);
        cycle();
        checks++;
        if (obs_ready !== N'(8)) begin
            errors++;
            $display("FAIL sparse_first: got %b expected %b", obs_ready, N'(8));
        end
        cycle();
        checks++;
        if (obs_ready !== N'(2)) begin
            errors++;
            $display("FAIL sparse_second: got %b expected %b", obs_ready, N'(2));
        end
        drain();
    endtask

    task automatic test_random();
        do_reset();
        for (int k = 0; k < 400; k++) begin
            req_valid = N'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            cycle();
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_truncation();
        test_backpressure();
        test_reset_midflight();
        test_sparse();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
